// File: rtl/mac_acc_stream_if.sv
// Operand and result handshake bundle for mac_acc_stream.
// The producer/consumer side uses master; the MAC itself uses slave.
interface mac_acc_stream_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] In1;
  logic signed [DATA_W-1:0] In2;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  Out;
  logic                     out_ovf;

  modport master (
    output in_valid, In1, In2, out_ready,
    input  in_ready, out_valid, Out, out_ovf
  );

  modport slave (
    input  in_valid, In1, In2, out_ready,
    output in_ready, out_valid, Out, out_ovf
  );
endinterface

// File: rtl/mac_acc_stream.sv
// Streaming signed multiply-accumulate over windows of TAPS*CH_GRP*(cfg_ci+1)
// operand pairs; two-stage pipeline with optional saturation and overflow flag.
module mac_acc_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 25,
  parameter int TAPS   = 16,
  parameter int CH_GRP = 8,
  parameter int CFG_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_conv,
  input  logic             end_conv,
  input  logic [CFG_W-1:0] cfg_ci,
  input  logic             cfg_sat,
  mac_acc_stream_if.slave  bus
);
  localparam int P_W   = 2 * DATA_W;
  localparam int N_MAX = TAPS * CH_GRP * (2 ** CFG_W);
  localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        lim_q, lim_d;
  logic                    sat_q, sat_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    p_valid_q, p_valid_d;
  logic                    p_first_q, p_first_d;
  logic                    p_last_q, p_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_q, out_d;
  logic                    out_ovf_q, out_ovf_d;

  logic                    stall, in_ready, accept;
  logic signed [P_W-1:0]   a_ext, b_ext;
  logic signed [ACC_W:0]   sum;
  logic                    ovf, sticky_nxt;
  logic signed [ACC_W-1:0] res;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    sat_d       = sat_q;
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    a_ext       = {{DATA_W{bus.In1[DATA_W-1]}}, bus.In1};
    b_ext       = {{DATA_W{bus.In2[DATA_W-1]}}, bus.In2};

    // The window-closing product cannot leave stage 1 while the previous result is unread.
    stall    = p_valid_q && p_last_q && out_valid_q && !bus.out_ready;
    in_ready = (state_q == S_RUN) && !end_conv && !stall;
    accept   = bus.in_valid && in_ready;

    if (state_q == S_IDLE) begin
      state_d = S_RUN;
      lim_d   = CNT_W'(TAPS * CH_GRP * (int'(cfg_ci) + 1) - 1);
      sat_d   = cfg_sat;
    end

    if (accept) begin
      p_d       = a_ext * b_ext;
      p_valid_d = 1'b1;
      p_first_d = (cnt_q == '0);
      p_last_d  = (cnt_q == lim_q);
      cnt_d     = (cnt_q == lim_q) ? '0 : cnt_q + CNT_W'(1);
    end else if (!stall) begin
      p_valid_d = 1'b0;
    end

    sum        = (p_first_q ? '0 : {acc_q[ACC_W-1], acc_q})
               + {{(ACC_W+1-P_W){p_q[P_W-1]}}, p_q};
    ovf        = sum[ACC_W] ^ sum[ACC_W-1];
    res        = (ovf && sat_q) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    sticky_nxt = (p_first_q ? 1'b0 : sticky_q) | ovf;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (p_valid_q && !stall) begin
      acc_d    = res;
      sticky_d = sticky_nxt;
      if (p_last_q) begin
        out_d       = res;
        out_ovf_d   = sticky_nxt;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !start_conv) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lim_q       <= '0;
      sat_q       <= 1'b0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      sat_q       <= sat_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_acc_stream.sv
// Scoreboard bench: drives a 25-bit and a 20-bit accumulator instance in lockstep
// and compares every delivered window result against a per-element model.
module tb_mac_acc_stream;
  logic       clk = 1'b0;
  logic       rst, start_conv, end_conv, cfg_sat;
  logic [1:0] cfg_ci;

  always #5 clk = ~clk;

  mac_acc_stream_if #(.DATA_W(8), .ACC_W(25)) bus_a ();
  mac_acc_stream_if #(.DATA_W(8), .ACC_W(20)) bus_b ();

  mac_acc_stream #(.DATA_W(8), .ACC_W(25), .TAPS(16), .CH_GRP(8), .CFG_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .start_conv(start_conv), .end_conv(end_conv),
    .cfg_ci(cfg_ci), .cfg_sat(cfg_sat), .bus(bus_a.slave)
  );

  mac_acc_stream #(.DATA_W(8), .ACC_W(20), .TAPS(16), .CH_GRP(8), .CFG_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start_conv(start_conv), .end_conv(end_conv),
    .cfg_ci(cfg_ci), .cfg_sat(cfg_sat), .bus(bus_b.slave)
  );

  typedef struct {
    longint oa; bit fa;
    longint ob; bit fb;
    int     cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     checks = 0, failures = 0, cyc = 0, acc_cnt = 0;
  bit     t_rst, t_start, t_end, t_ordy;
  bit     mrun, msat, lat_chk, prev_clr;
  int     mcnt, mlim;
  longint ma, mb;
  bit     sa, sb;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void accum(inout longint acc, inout bit st, input longint p,
                                input bit first, input int w, input bit sat);
    longint s, mx, mn, m;
    bit     o;
    m  = longint'(1) <<< w;
    mx = (m >>> 1) - 1;
    mn = -(m >>> 1);
    s  = (first ? 0 : acc) + p;
    o  = (s > mx) || (s < mn);
    if (o) begin
      if (sat) s = (s > mx) ? mx : mn;
      else begin
        s = s & (m - 1);
        if (s > mx) s = s - m;
      end
    end
    st  = (first ? 1'b0 : st) | o;
    acc = s;
  endfunction

  function automatic void model_accept(input int a, input int b);
    longint p;
    bit     first, last;
    exp_t   e;
    p     = longint'(a) * longint'(b);
    first = (mcnt == 0);
    last  = (mcnt == mlim);
    accum(ma, sa, p, first, 25, msat);
    accum(mb, sb, p, first, 20, msat);
    acc_cnt++;
    if (last) begin
      e.oa = ma; e.fa = sa; e.ob = mb; e.fb = sb; e.cyc = cyc;
      sb_q.push_back(e);
    end
    mcnt = last ? 0 : mcnt + 1;
  endfunction

  task automatic monitor();
    exp_t e;
    if (bus_a.out_valid && t_ordy) begin
      if (sb_q.size() == 0) check_val("spurious_out", bus_a.out_valid, 0);
      else begin
        e = sb_q.pop_front();
        check_val("out_a", bus_a.Out, e.oa);
        check_val("ovf_a", bus_a.out_ovf, e.fa);
        check_val("vld_b", bus_b.out_valid, 1);
        check_val("out_b", bus_b.Out, e.ob);
        check_val("ovf_b", bus_b.out_ovf, e.fb);
        if (lat_chk) check_val("latency", cyc - e.cyc, 2);
      end
    end else if (bus_a.out_valid && sb_q.size() > 0) begin
      check_val("hold_a", bus_a.Out, sb_q[0].oa);
      check_val("hold_b", bus_b.Out, sb_q[0].ob);
    end
  endtask

  task automatic step(input bit v, input int a, input int b);
    @(negedge clk);
    rst = t_rst; start_conv = t_start; end_conv = t_end;
    bus_a.out_ready = t_ordy;  bus_b.out_ready = t_ordy;
    bus_a.in_valid  = v;       bus_b.in_valid  = v;
    bus_a.In1 = 8'(a); bus_a.In2 = 8'(b);
    bus_b.In1 = 8'(a); bus_b.In2 = 8'(b);
    #1;
    if (prev_clr) begin
      check_val("clr_vld", bus_a.out_valid, 0);
      check_val("clr_out", bus_a.Out, 0);
      check_val("clr_ovf", bus_a.out_ovf, 0);
      check_val("clr_rdy", bus_a.in_ready, 0);
      check_val("clr_out_b", bus_b.Out, 0);
    end
    if (t_rst || !t_start) begin
      sb_q.delete();
      mcnt = 0; mrun = 1'b0; prev_clr = 1'b1;
    end else begin
      prev_clr = 1'b0;
      if (!mrun) begin
        check_val("idle_rdy", bus_a.in_ready, 0);
        mrun = 1'b1;
        mlim = 128 * (int'(cfg_ci) + 1) - 1;
        msat = cfg_sat;
      end else if (v && bus_a.in_ready && bus_b.in_ready) begin
        model_accept(a, b);
      end
      monitor();
    end
    cyc++;
  endtask

  task automatic feed(input int n, input bit rnd, input int a, input int b, input int vpct);
    int start, budget, x, y;
    bit v;
    start  = acc_cnt;
    budget = n * 10 + 100;
    while ((acc_cnt - start) < n && budget > 0) begin
      v = ($urandom_range(99) < vpct);
      x = rnd ? int'($urandom_range(255)) - 128 : a;
      y = rnd ? int'($urandom_range(255)) - 128 : b;
      step(v, x, y);
      budget--;
    end
    check_val("feed_cnt", acc_cnt - start, n);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 0, 0);
    check_val("pending", sb_q.size(), 0);
  endtask

  task automatic restart(input logic [1:0] ci, input bit s);
    t_start = 1'b0;
    step(1'b0, 0, 0);
    cfg_ci  = ci;
    cfg_sat = s;
    t_start = 1'b1;
    step(1'b0, 0, 0);
  endtask

  initial begin
    int start;
    t_rst = 1'b1; t_start = 1'b0; t_end = 1'b0; t_ordy = 1'b1;
    cfg_ci = 2'd0; cfg_sat = 1'b0;
    lat_chk = 1'b0; prev_clr = 1'b0; mrun = 1'b0; mcnt = 0;
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    t_rst = 1'b0; t_start = 1'b1;

    // continuous N=128 windows, latency 2 with no inter-window gap
    lat_chk = 1'b1;
    feed(384, 1'b0, 1, 2, 100);
    drain(4);
    lat_chk = 1'b0;

    // N=512 extremes
    restart(2'd3, 1'b0);
    feed(512, 1'b0, -128, -128, 100);
    feed(512, 1'b0, -128, 127, 100);
    drain(4);

    // overflow on the 20-bit instance: saturate, then wrap, then clean window
    restart(2'd0, 1'b1);
    feed(128, 1'b0, -128, -128, 100);
    drain(4);
    restart(2'd0, 1'b0);
    feed(128, 1'b0, -128, -128, 100);
    feed(128, 1'b0, 1, 1, 100);
    drain(4);

    // back-pressure: output blocked for 300 cycles
    restart(2'd0, 1'b0);
    t_ordy = 1'b0;
    start  = acc_cnt;
    for (int i = 0; i < 300; i++) step(1'b1, 1, 2);
    check_val("stall_acc", acc_cnt - start, 256);
    check_val("stall_rdy", bus_a.in_ready, 0);
    t_ordy = 1'b1;
    drain(6);

    // end_conv pause mid-window with random gaps; cfg change in RUN ignored
    restart(2'd1, 1'b0);
    feed(100, 1'b1, 0, 0, 70);
    t_end = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5, 5);
      check_val("end_rdy", bus_a.in_ready, 0);
    end
    t_end   = 1'b0;
    cfg_ci  = 2'd3;
    cfg_sat = 1'b1;
    feed(412, 1'b1, 0, 0, 70);
    drain(6);

    // reset at element 60, clear at element 100, then a clean window
    restart(2'd0, 1'b0);
    feed(60, 1'b0, 1, 2, 100);
    t_rst = 1'b1;
    step(1'b0, 0, 0);
    t_rst = 1'b0;
    feed(100, 1'b0, 1, 2, 100);
    t_start = 1'b0;
    step(1'b0, 0, 0);
    t_start = 1'b1;
    feed(128, 1'b0, 1, 2, 100);
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
